// File: rtl/inference_run_monitor.sv
// Run monitor for MLP-inference programs. It snoops register-file write-back,
// counts cycles and retired instructions, and computes accuracy in basis points.
//
// state     | meaning
// S_IDLE    | after reset, waiting for start_i
// S_RUN     | program running: counting, snooping, watchdog armed
// S_DIV     | exit seen: sequential restoring divide, counters frozen
// S_DONE    | accuracy valid, outputs held until start_i
// S_TIMEOUT | watchdog fired, counters held until start_i
module inference_run_monitor #(
  parameter int DWidth        = 32,
  parameter int RegAddrW      = 5,
  parameter int NumOfTest     = 10000,
  parameter int ExitReg       = 25,
  parameter int ExitMagic     = 99999,
  parameter int ImageReg      = 26,
  parameter int CorrectReg    = 27,
  parameter int TimeoutCycles = 0,
  parameter int CntWidth      = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                wb_we_i,
  input  logic [RegAddrW-1:0] wb_addr_i,
  input  logic [DWidth-1:0]   wb_data_i,
  input  logic                retire_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic                err_o,
  output logic                progress_o,
  output logic [DWidth-1:0]   image_cnt_o,
  output logic [DWidth-1:0]   correct_cnt_o,
  output logic [CntWidth-1:0] cycle_cnt_o,
  output logic [CntWidth-1:0] instret_cnt_o,
  output logic [13:0]         acc_bp_o,
  output logic                acc_valid_o
);

  localparam int DivW    = $clog2(longint'(NumOfTest) * 10000 + 1);
  localparam int NumW    = $clog2(NumOfTest + 1);
  localparam int RemW    = NumW + 1;
  localparam int DivCntW = $clog2(DivW + 1);

  localparam logic [RemW-1:0]     Divisor  = RemW'(NumOfTest);
  localparam bit                  WdogEn   = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] WdogLoad = WdogEn ? CntWidth'(TimeoutCycles - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DIV,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t               r_state;
  logic [CntWidth-1:0]  r_cycle_cnt;
  logic [CntWidth-1:0]  r_instret_cnt;
  logic [CntWidth-1:0]  r_wdog;
  logic [DWidth-1:0]    r_image_cnt;
  logic [DWidth-1:0]    r_correct_cnt;
  logic                 r_progress;
  logic                 r_done;
  logic                 r_timeout;
  logic                 r_err;
  logic                 r_acc_valid;
  logic [13:0]          r_acc_bp;
  logic [DivW-1:0]      r_num;
  logic [NumW-1:0]      r_rem;
  logic [DivCntW-1:0]   r_div_cnt;

  logic                 w_wr_vld;
  logic                 w_exit;
  logic                 w_img_wr;
  logic                 w_corr_wr;
  logic                 w_wdog_fire;
  logic                 w_corr_over;
  logic [NumW-1:0]      w_corr_sat;
  logic [DivW-1:0]      w_num;
  logic [RemW-1:0]      w_rem_sh;
  logic                 w_rem_ge;
  logic [NumW-1:0]      w_rem_nxt;
  logic [DivW-1:0]      w_quo_nxt;

  assign w_wr_vld    = wb_we_i && (wb_addr_i != '0);
  assign w_exit      = w_wr_vld && (wb_addr_i == RegAddrW'(ExitReg))
                       && (wb_data_i == DWidth'(ExitMagic));
  assign w_img_wr    = w_wr_vld && (wb_addr_i == RegAddrW'(ImageReg));
  assign w_corr_wr   = w_wr_vld && (wb_addr_i == RegAddrW'(CorrectReg));
  assign w_wdog_fire = WdogEn && (r_wdog == '0);

  // Numerator saturates at NumOfTest so accuracy never exceeds 10000 bp.
  assign w_corr_over = (r_correct_cnt > DWidth'(NumOfTest));
  assign w_corr_sat  = w_corr_over ? NumW'(NumOfTest) : r_correct_cnt[NumW-1:0];
  assign w_num       = DivW'(w_corr_sat) * DivW'(10000);

  // r_num shifts the numerator out of its top while quotient bits enter at the bottom.
  assign w_rem_sh  = {r_rem, r_num[DivW-1]};
  assign w_rem_ge  = (w_rem_sh >= Divisor);
  assign w_rem_nxt = NumW'(w_rem_ge ? (w_rem_sh - Divisor) : w_rem_sh);
  assign w_quo_nxt = {r_num[DivW-2:0], w_rem_ge};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
      r_wdog        <= '0;
      r_image_cnt   <= '0;
      r_correct_cnt <= '0;
      r_progress    <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_err         <= 1'b0;
      r_acc_valid   <= 1'b0;
      r_acc_bp      <= '0;
      r_num         <= '0;
      r_rem         <= '0;
      r_div_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          r_progress <= 1'b0;
          if (start_i) begin
            r_state       <= S_RUN;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
            r_wdog        <= WdogLoad;
            r_image_cnt   <= '0;
            r_correct_cnt <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_err         <= 1'b0;
            r_acc_valid   <= 1'b0;
            r_acc_bp      <= '0;
            r_num         <= '0;
            r_rem         <= '0;
            r_div_cnt     <= '0;
          end
        end
        S_RUN: begin
          r_cycle_cnt   <= r_cycle_cnt + CntWidth'(1);
          r_instret_cnt <= r_instret_cnt + CntWidth'(retire_i);
          r_progress    <= w_img_wr && (wb_data_i != r_image_cnt);
          if (r_wdog != '0) r_wdog <= r_wdog - CntWidth'(1);
          if (w_img_wr)  r_image_cnt   <= wb_data_i;
          if (w_corr_wr) r_correct_cnt <= wb_data_i;
          if (w_exit) begin
            r_state   <= S_DIV;
            r_err     <= w_corr_over;
            r_num     <= w_num;
            r_rem     <= '0;
            r_div_cnt <= DivCntW'(DivW - 1);
          end else if (w_wdog_fire) begin
            r_state   <= S_TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        S_DIV: begin
          r_progress <= 1'b0;
          r_num      <= w_quo_nxt;
          r_rem      <= w_rem_nxt;
          if (r_div_cnt == '0) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_acc_valid <= 1'b1;
            r_acc_bp    <= w_quo_nxt[13:0];
          end else begin
            r_div_cnt <= r_div_cnt - DivCntW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = (r_state == S_RUN) || (r_state == S_DIV);
  assign done_o        = r_done;
  assign timeout_o     = r_timeout;
  assign err_o         = r_err;
  assign progress_o    = r_progress;
  assign image_cnt_o   = r_image_cnt;
  assign correct_cnt_o = r_correct_cnt;
  assign cycle_cnt_o   = r_cycle_cnt;
  assign instret_cnt_o = r_instret_cnt;
  assign acc_bp_o      = r_acc_bp;
  assign acc_valid_o   = r_acc_valid;

endmodule

// File: tb/tb_inference_run_monitor.sv
// Directed bench for inference_run_monitor with NumOfTest=10, TimeoutCycles=100.
module tb_inference_run_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        retire_i = 1'b0;
  logic        busy_o, done_o, timeout_o, err_o, progress_o, acc_valid_o;
  logic [31:0] image_cnt_o, correct_cnt_o;
  logic [63:0] cycle_cnt_o, instret_cnt_o;
  logic [13:0] acc_bp_o;

  int checks = 0;
  int errors = 0;

  inference_run_monitor #(
    .NumOfTest(10),
    .TimeoutCycles(100)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .retire_i(retire_i), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .err_o(err_o), .progress_o(progress_o),
    .image_cnt_o(image_cnt_o), .correct_cnt_o(correct_cnt_o),
    .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o),
    .acc_bp_o(acc_bp_o), .acc_valid_o(acc_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1'b1; wb_addr_i = a; wb_data_i = d;
    tick(1);
    wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(2);
    checks++; if ({busy_o, done_o, timeout_o, err_o, progress_o, acc_valid_o} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b exp 000000", {busy_o, done_o, timeout_o, err_o, progress_o, acc_valid_o}); end
    checks++; if ({cycle_cnt_o, instret_cnt_o} !== 128'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", cycle_cnt_o, instret_cnt_o); end
    checks++; if ({image_cnt_o, correct_cnt_o, acc_bp_o} !== 78'd0) begin errors++; $display("FAIL rst_regs got %0d/%0d/%0d exp 0/0/0", image_cnt_o, correct_cnt_o, acc_bp_o); end
    rst_ni = 1'b1;
    tick(1);
    wr(5'd26, 32'd3);
    checks++; if (image_cnt_o !== 32'd0) begin errors++; $display("FAIL idle_write got %0d exp 0", image_cnt_o); end
  endtask

  task automatic test_accuracy();
    do_start();
    retire_i = 1'b1;
    wr(5'd27, 32'd9);
    wr(5'd25, 32'd99999);
    checks++; if ({busy_o, done_o} !== 2'b10) begin errors++; $display("FAIL acc_enter_div got %b exp 10", {busy_o, done_o}); end
    checks++; if (cycle_cnt_o !== 64'd2) begin errors++; $display("FAIL acc_exit_cycle got %0d exp 2", cycle_cnt_o); end
    tick(16);
    checks++; if ({busy_o, done_o} !== 2'b10) begin errors++; $display("FAIL acc_div_len16 got %b exp 10", {busy_o, done_o}); end
    tick(1);
    checks++; if ({busy_o, done_o, acc_valid_o, err_o} !== 4'b0110) begin errors++; $display("FAIL acc_done_flags got %b exp 0110", {busy_o, done_o, acc_valid_o, err_o}); end
    checks++; if (acc_bp_o !== 14'd9000) begin errors++; $display("FAIL acc_bp9 got %0d exp 9000", acc_bp_o); end
    checks++; if ({cycle_cnt_o, instret_cnt_o} !== {64'd2, 64'd2}) begin errors++; $display("FAIL acc_frozen got %0d/%0d exp 2/2", cycle_cnt_o, instret_cnt_o); end
    retire_i = 1'b0;
  endtask

  task automatic test_restart();
    tick(3);
    checks++; if ({done_o, acc_bp_o} !== {1'b1, 14'd9000}) begin errors++; $display("FAIL done_hold got %b/%0d exp 1/9000", done_o, acc_bp_o); end
    do_start();
    checks++; if ({busy_o, done_o, acc_valid_o} !== 3'b100) begin errors++; $display("FAIL restart_flags got %b exp 100", {busy_o, done_o, acc_valid_o}); end
    checks++; if ({acc_bp_o, correct_cnt_o} !== 46'd0) begin errors++; $display("FAIL restart_regs got %0d/%0d exp 0/0", acc_bp_o, correct_cnt_o); end
    checks++; if ({cycle_cnt_o, instret_cnt_o} !== 128'd0) begin errors++; $display("FAIL restart_cnt got %0d/%0d exp 0/0", cycle_cnt_o, instret_cnt_o); end
  endtask

  task automatic test_timeout();
    retire_i = 1'b1;
    tick(10);
    retire_i = 1'b0;
    tick(89);
    checks++; if ({busy_o, timeout_o} !== 2'b10 || cycle_cnt_o !== 64'd99) begin errors++; $display("FAIL wdog_early got %b/%0d exp 10/99", {busy_o, timeout_o}, cycle_cnt_o); end
    tick(1);
    checks++; if ({busy_o, timeout_o, done_o, acc_valid_o} !== 4'b0100) begin errors++; $display("FAIL wdog_flags got %b exp 0100", {busy_o, timeout_o, done_o, acc_valid_o}); end
    checks++; if (cycle_cnt_o !== 64'd100) begin errors++; $display("FAIL wdog_cycle got %0d exp 100", cycle_cnt_o); end
    checks++; if (instret_cnt_o !== 64'd10) begin errors++; $display("FAIL wdog_instret got %0d exp 10", instret_cnt_o); end
    tick(3);
    checks++; if ({timeout_o, cycle_cnt_o} !== {1'b1, 64'd100}) begin errors++; $display("FAIL wdog_hold got %b/%0d exp 1/100", timeout_o, cycle_cnt_o); end
  endtask

  task automatic test_ignored_writes();
    wr(5'd26, 32'd5);
    wr(5'd27, 32'd3);
    wr(5'd25, 32'd99999);
    checks++; if ({image_cnt_o, correct_cnt_o} !== 64'd0) begin errors++; $display("FAIL pre_start_wr got %0d/%0d exp 0/0", image_cnt_o, correct_cnt_o); end
    checks++; if ({timeout_o, done_o} !== 2'b10) begin errors++; $display("FAIL pre_start_exit got %b exp 10", {timeout_o, done_o}); end
    do_start();
    checks++; if ({busy_o, timeout_o} !== 2'b10) begin errors++; $display("FAIL ign_start got %b exp 10", {busy_o, timeout_o}); end
    wr(5'd25, 32'd99998);
    tick(20);
    checks++; if ({busy_o, done_o, cycle_cnt_o} !== {2'b10, 64'd21}) begin errors++; $display("FAIL wrong_magic got %b/%0d exp 10/21", {busy_o, done_o}, cycle_cnt_o); end
    wr(5'd0, 32'd99999);
    wb_we_i = 1'b0; wb_addr_i = 5'd25; wb_data_i = 32'd99999;
    tick(1);
    wb_addr_i = '0; wb_data_i = '0;
    checks++; if ({busy_o, done_o, cycle_cnt_o} !== {2'b10, 64'd23}) begin errors++; $display("FAIL x0_or_we0 got %b/%0d exp 10/23", {busy_o, done_o}, cycle_cnt_o); end
    wr(5'd27, 32'd7);
    wr(5'd25, 32'd99999);
    checks++; if ({image_cnt_o, correct_cnt_o} !== {32'd0, 32'd7}) begin errors++; $display("FAIL ign_regs got %0d/%0d exp 0/7", image_cnt_o, correct_cnt_o); end
    tick(17);
    checks++; if ({done_o, acc_bp_o} !== {1'b1, 14'd7000}) begin errors++; $display("FAIL ign_done got %b/%0d exp 1/7000", done_o, acc_bp_o); end
    checks++; if (cycle_cnt_o !== 64'd25) begin errors++; $display("FAIL ign_cycle got %0d exp 25", cycle_cnt_o); end
  endtask

  task automatic test_err_saturate();
    do_start();
    wr(5'd27, 32'd11);
    wr(5'd25, 32'd99999);
    checks++; if ({err_o, correct_cnt_o} !== {1'b1, 32'd11}) begin errors++; $display("FAIL err_set got %b/%0d exp 1/11", err_o, correct_cnt_o); end
    tick(17);
    checks++; if ({done_o, err_o, acc_bp_o} !== {2'b11, 14'd10000}) begin errors++; $display("FAIL err_acc got %b/%0d exp 11/10000", {done_o, err_o}, acc_bp_o); end
  endtask

  task automatic test_progress_and_race();
    int pulses;
    logic [31:0] img_vals [4];
    img_vals = '{32'd0, 32'd1, 32'd1, 32'd2};
    pulses = 0;
    do_start();
    for (int i = 0; i < 4; i++) begin
      wr(5'd26, img_vals[i]);
      if (progress_o === 1'b1) pulses++;
      if (i == 1) begin
        checks++; if (progress_o !== 1'b1) begin errors++; $display("FAIL prog_timing got %b exp 1", progress_o); end
      end
    end
    wr(5'd27, 32'd4);
    if (progress_o === 1'b1) pulses++;
    checks++; if (pulses !== 2) begin errors++; $display("FAIL prog_pulses got %0d exp 2", pulses); end
    checks++; if (image_cnt_o !== 32'd2) begin errors++; $display("FAIL prog_image got %0d exp 2", image_cnt_o); end
    do_start();
    checks++; if ({busy_o, cycle_cnt_o} !== {1'b1, 64'd6}) begin errors++; $display("FAIL start_in_run got %b/%0d exp 1/6", busy_o, cycle_cnt_o); end
    tick(93);
    checks++; if ({timeout_o, cycle_cnt_o} !== {1'b0, 64'd99}) begin errors++; $display("FAIL race_pre got %b/%0d exp 0/99", timeout_o, cycle_cnt_o); end
    wr(5'd25, 32'd99999);
    checks++; if ({busy_o, timeout_o, cycle_cnt_o} !== {2'b10, 64'd100}) begin errors++; $display("FAIL race_div got %b/%0d exp 10/100", {busy_o, timeout_o}, cycle_cnt_o); end
    tick(17);
    checks++; if ({done_o, timeout_o, acc_bp_o} !== {2'b10, 14'd4000}) begin errors++; $display("FAIL race_done got %b/%0d exp 10/4000", {done_o, timeout_o}, acc_bp_o); end
  endtask

  task automatic test_reset_mid_div();
    do_start();
    wr(5'd27, 32'd5);
    wr(5'd25, 32'd99999);
    tick(5);
    checks++; if ({busy_o, done_o} !== 2'b10) begin errors++; $display("FAIL middiv_pre got %b exp 10", {busy_o, done_o}); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if ({busy_o, done_o, err_o, acc_valid_o} !== 4'b0 || {cycle_cnt_o, correct_cnt_o} !== 96'd0) begin errors++; $display("FAIL async_rst got %b/%0d/%0d exp 0000/0/0", {busy_o, done_o, err_o, acc_valid_o}, cycle_cnt_o, correct_cnt_o); end
    tick(2);
    rst_ni = 1'b1;
    tick(20);
    checks++; if ({busy_o, done_o, acc_bp_o} !== 16'd0) begin errors++; $display("FAIL post_rst_idle got %b/%0d exp 00/0", {busy_o, done_o}, acc_bp_o); end
  endtask

  initial begin
    test_reset();
    test_accuracy();
    test_restart();
    test_timeout();
    test_ignored_writes();
    test_err_saturate();
    test_progress_and_race();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
